watchdog_kicker: RTL and testbench



---
 rtl/watchdog_pkg.sv | 18 +
 rtl/kick_period_timer.sv | 28 ++
 rtl/watchdog_kicker.sv | 133 +++++++++++++
 tb/tb_watchdog_kicker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/watchdog_pkg.sv
// Shared state encoding and kick-sequence helper for the watchdog kick generator.
package watchdog_pkg;

  localparam int EXPIRE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_HOLDOFF = 2'b10,
    ST_FAULT   = 2'b11
  } kick_state_t;

  // Skips 0 on wrap so every kick differs from the watchdog's reset capture value.
  function automatic logic [7:0] next_kick(input logic [7:0] cur);
    return (cur == 8'hFF) ? 8'h01 : cur + 8'h01;
  endfunction

endpackage

// File: rtl/kick_period_timer.sv
// Up-counter that pulses tc on the last cycle of a period and wraps itself;
// clr restarts the period and takes priority over counting.
module kick_period_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == period - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/watchdog_kicker.sv
// Heartbeat source for the watchdog: kicks at a programmable interval and
// supervises expiries through a holdoff/retry path into a sticky fault.
module watchdog_kicker
  import watchdog_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 16,
  parameter int MAX_EXPIRES    = 3,
  parameter int PERIOD_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    start,
  input  logic                    stop,
  input  logic [PERIOD_W-1:0]     kick_period,
  input  logic                    watchdog_expired,
  output logic [7:0]              kick_out,
  output logic                    kick_strobe,
  output logic                    active,
  output logic                    fault,
  output logic [EXPIRE_CNT_W-1:0] expire_count
);

  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HOLD_W-1:0]       HOLD_PERIOD = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [EXPIRE_CNT_W-1:0] MAX_CNT     = EXPIRE_CNT_W'(MAX_EXPIRES);

  kick_state_t                state, state_nxt;
  logic [PERIOD_W-1:0]        latched_period;
  logic                       expired_prev;
  logic                       expire_evt;
  logic [EXPIRE_CNT_W-1:0]    expire_inc;
  logic                       period_tc, hold_tc;
  logic                       kick_now, run_clr, hold_clr, cnt_clr, cnt_inc, latch_period;

  assign expire_evt = watchdog_expired && !expired_prev;
  assign expire_inc = (expire_count == '1) ? expire_count : expire_count + 1'b1;
  assign active     = (state == ST_RUN);
  assign fault      = (state == ST_FAULT);

  kick_period_timer #(.CNT_W(PERIOD_W)) u_period_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena && (state == ST_RUN)),
    .clr    (run_clr),
    .period (latched_period),
    .tc     (period_tc)
  );

  kick_period_timer #(.CNT_W(HOLD_W)) u_holdoff_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena && (state == ST_HOLDOFF)),
    .clr    (hold_clr),
    .period (HOLD_PERIOD),
    .tc     (hold_tc)
  );

  // Priority: stop > expiry > kick; nothing moves while ena is low.
  always_comb begin
    state_nxt    = state;
    kick_now     = 1'b0;
    run_clr      = 1'b0;
    hold_clr     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    latch_period = 1'b0;
    if (ena) begin
      if (stop) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state_nxt    = ST_RUN;
              kick_now     = 1'b1;
              run_clr      = 1'b1;
              cnt_clr      = 1'b1;
              latch_period = 1'b1;
            end
          end
          ST_RUN, ST_HOLDOFF: begin
            if (expire_evt) begin
              cnt_inc = 1'b1;
              if (expire_inc >= MAX_CNT) begin
                state_nxt = ST_FAULT;
              end else begin
                state_nxt = ST_HOLDOFF;
                hold_clr  = 1'b1;
              end
            end else if (state == ST_RUN) begin
              kick_now = period_tc;
            end else if (hold_tc) begin
              state_nxt = ST_RUN;
              kick_now  = 1'b1;
              run_clr   = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      latched_period <= '0;
      expired_prev   <= 1'b0;
      kick_out       <= '0;
      kick_strobe    <= 1'b0;
      expire_count   <= '0;
    end else begin
      state       <= state_nxt;
      kick_strobe <= kick_now;
      if (ena) begin
        expired_prev <= watchdog_expired;
      end
      if (latch_period) begin
        latched_period <= (kick_period == '0) ? PERIOD_W'(1) : kick_period;
      end
      if (kick_now) begin
        kick_out <= next_kick(kick_out);
      end
      if (cnt_clr) begin
        expire_count <= '0;
      end else if (cnt_inc) begin
        expire_count <= expire_inc;
      end
    end
  end

endmodule

// File: tb/tb_watchdog_kicker.sv
// Randomised and directed stimulus for watchdog_kicker, checked every cycle
// against a countdown-style behavioural model of the kick/expiry rules.
module tb_watchdog_kicker;

  localparam int HOLDOFF = 16;
  localparam int MAXEXP  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HOLD  = 2;
  localparam int M_FAULT = 3;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       stop;
  logic [7:0] kick_period;
  logic       wexp;
  logic [7:0] kick_out;
  logic       kick_strobe;
  logic       active;
  logic       fault;
  logic [3:0] expire_count;

  int n_cmp;
  int n_err;

  int m_mode;
  int m_kick;
  int m_strobe;
  int m_count;
  int m_period;
  int m_since;
  int m_hold_left;
  int m_prev;

  watchdog_kicker #(
    .HOLDOFF_CYCLES (HOLDOFF),
    .MAX_EXPIRES    (MAXEXP),
    .PERIOD_W       (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ena              (ena),
    .start            (start),
    .stop             (stop),
    .kick_period      (kick_period),
    .watchdog_expired (wexp),
    .kick_out         (kick_out),
    .kick_strobe      (kick_strobe),
    .active           (active),
    .fault            (fault),
    .expire_count     (expire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_kick = 0; m_strobe = 0; m_count = 0;
    m_period = 1; m_since = 0; m_hold_left = 0; m_prev = 0;
  endtask

  task automatic model_kick();
    m_kick   = (m_kick == 255) ? 1 : m_kick + 1;
    m_strobe = 1;
    m_since  = 0;
    m_mode   = M_RUN;
  endtask

  task automatic model_step();
    bit rise;
    m_strobe = 0;
    if (!ena) return;
    rise   = wexp && (m_prev == 0);
    m_prev = wexp ? 1 : 0;
    if (stop) begin
      m_mode = M_IDLE;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (start) begin
          m_period = (kick_period == 0) ? 1 : int'(kick_period);
          m_count  = 0;
          model_kick();
        end
      end
      M_RUN, M_HOLD: begin
        if (rise) begin
          if (m_count < 15) m_count++;
          if (m_count >= MAXEXP) m_mode = M_FAULT;
          else begin
            m_mode      = M_HOLD;
            m_hold_left = HOLDOFF;
          end
        end else if (m_mode == M_RUN) begin
          m_since++;
          if (m_since >= m_period) model_kick();
        end else begin
          m_hold_left--;
          if (m_hold_left == 0) model_kick();
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    check_eq("kick_out",     32'(kick_out),     32'(m_kick));
    check_eq("kick_strobe",  32'(kick_strobe),  32'(m_strobe));
    check_eq("active",       32'(active),       32'(m_mode == M_RUN));
    check_eq("fault",        32'(fault),        32'(m_mode == M_FAULT));
    check_eq("expire_count", 32'(expire_count), 32'(m_count));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
      start = 1'b0;
      stop  = 1'b0;
    end
  endtask

  task automatic do_start(input logic [7:0] p);
    kick_period = p;
    start = 1'b1;
    cyc(1);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc(1);
  endtask

  task automatic reset_zero_check(input string tag);
    check_eq({tag, "_kick_out"},  32'(kick_out),     32'd0);
    check_eq({tag, "_strobe"},    32'(kick_strobe),  32'd0);
    check_eq({tag, "_active"},    32'(active),       32'd0);
    check_eq({tag, "_fault"},     32'(fault),        32'd0);
    check_eq({tag, "_exp_count"}, 32'(expire_count), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0;
    kick_period = 8'd4; wexp = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_zero_check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Plan 1: period 4, strobes every 4th cycle
    do_start(8'd4);
    cyc(16);

    // Plan 2: period 1 wraps 255 -> 1 with a strobe every cycle
    do_stop();
    do_start(8'd1);
    cyc(260);

    // Plan 3: a 3-cycle-high expiry counts once, then 16-cycle holdoff
    do_stop();
    do_start(8'd4);
    cyc(5);
    wexp = 1'b1; cyc(3);
    wexp = 1'b0; cyc(25);

    // Plan 4: three expiry edges drive FAULT; stop keeps count; start clears it
    do_stop();
    do_start(8'd3);
    cyc(4);
    for (int k = 0; k < 3; k++) begin
      wexp = 1'b1; cyc(1);
      wexp = 1'b0; cyc(4);
    end
    cyc(5);
    do_stop();
    cyc(2);
    do_start(8'd3);
    cyc(4);

    // Plan 5: period 0 behaves as 1; start+stop together from IDLE stays idle
    do_stop();
    do_start(8'd0);
    cyc(5);
    do_stop();
    start = 1'b1; stop = 1'b1; kick_period = 8'd2;
    cyc(3);

    // Plan 6: ena drop mid-period, then async reset mid-HOLDOFF
    do_start(8'd5);
    cyc(2);
    ena = 1'b0; wexp = 1'b1; cyc(10);
    wexp = 1'b0;
    ena = 1'b1; cyc(8);
    wexp = 1'b1; cyc(1);
    wexp = 1'b0; cyc(4);
    #2;
    rst_n = 1'b0;
    #1;
    reset_zero_check("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    reset_zero_check("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      ena         = ($urandom_range(0, 9) != 0);
      start       = ($urandom_range(0, 19) == 0);
      stop        = ($urandom_range(0, 59) == 0);
      kick_period = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 11) == 0) wexp = ~wexp;
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
